// File: rtl/serial_fb_writer.sv
// Byte-stream command parser that writes a 1bpp 320x240 framebuffer (set pointer, burst write, fill).
// Optional `PIXEL_WRITE_EN adds a read-modify-write single-pixel command with a RAM read port.
module serial_fb_writer #(
  parameter logic [13:0] FB_BYTES    = 14'd9600,
  parameter logic [7:0]  CMD_SETADDR = 8'hA0,
  parameter logic [7:0]  CMD_WRITE   = 8'hA1,
  parameter logic [7:0]  CMD_FILL    = 8'hA2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        cmd_error
`ifdef PIXEL_WRITE_EN
  ,
  output logic [13:0] fb_rd_addr,
  input  logic [7:0]  fb_rd_data
`endif
);

`ifdef PIXEL_WRITE_EN
  localparam logic [7:0] CMD_PIXEL = 8'hA3;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_COUNT, S_DATA, S_FILL_VAL, S_FILLING
`ifdef PIXEL_WRITE_EN
    , S_PX_XHI, S_PX_XLO, S_PX_Y, S_PX_COL, S_PX_RD, S_PX_CAP
`endif
  } state_t;

  state_t      r_state, w_state_n;
  logic [13:0] r_ptr, w_ptr_n;
  logic [5:0]  r_addr_hi, w_addr_hi_n;
  logic [8:0]  r_remain, w_remain_n;
  logic [7:0]  r_fill_val, w_fill_val_n;
  logic [13:0] r_fill_cnt, w_fill_cnt_n;
  logic        r_wr_en, w_wr_en_n;
  logic [13:0] r_wr_addr, w_wr_addr_n;
  logic [7:0]  r_wr_data, w_wr_data_n;
  logic        r_busy, w_busy_n;
  logic        r_err, w_err_n;
  logic        w_byte;
  logic [13:0] w_addr_full;

`ifdef PIXEL_WRITE_EN
  logic [8:0]  r_px_x, w_px_x_n;
  logic [7:0]  r_px_y, w_px_y_n;
  logic        r_px_c, w_px_c_n;
  logic [13:0] r_rd_addr, w_rd_addr_n;
  logic [13:0] w_px_addr;
  logic [7:0]  w_px_byte;
`endif

  // Bytes arriving while busy are dropped; only non-busy strobes advance the parser.
  assign w_byte      = rx_valid & ~r_busy;
  assign w_addr_full = {r_addr_hi, rx_data};

  always_comb begin
    w_state_n    = r_state;
    w_ptr_n      = r_ptr;
    w_addr_hi_n  = r_addr_hi;
    w_remain_n   = r_remain;
    w_fill_val_n = r_fill_val;
    w_fill_cnt_n = r_fill_cnt;
    w_wr_en_n    = 1'b0;
    w_wr_addr_n  = r_wr_addr;
    w_wr_data_n  = r_wr_data;
    w_busy_n     = 1'b0;
    w_err_n      = r_err | (rx_valid & r_busy);
`ifdef PIXEL_WRITE_EN
    w_px_x_n     = r_px_x;
    w_px_y_n     = r_px_y;
    w_px_c_n     = r_px_c;
    w_rd_addr_n  = r_rd_addr;
    w_px_addr    = ({6'd0, r_px_y} << 5) + ({6'd0, r_px_y} << 3) + {8'd0, r_px_x[8:3]};
    w_px_byte    = fb_rd_data;
    w_px_byte[r_px_x[2:0]] = r_px_c;
`endif
    case (r_state)
      S_IDLE: if (w_byte) begin
        case (rx_data)
          CMD_SETADDR: w_state_n = S_ADDR_HI;
          CMD_WRITE:   w_state_n = S_COUNT;
          CMD_FILL:    w_state_n = S_FILL_VAL;
`ifdef PIXEL_WRITE_EN
          CMD_PIXEL:   w_state_n = S_PX_XHI;
`endif
          default:     w_err_n   = 1'b1;
        endcase
      end
      S_ADDR_HI: if (w_byte) begin
        w_addr_hi_n = rx_data[5:0];
        w_state_n   = S_ADDR_LO;
      end
      S_ADDR_LO: if (w_byte) begin
        if (w_addr_full < FB_BYTES) w_ptr_n = w_addr_full;
        else begin
          w_ptr_n = 14'd0;
          w_err_n = 1'b1;
        end
        w_state_n = S_IDLE;
      end
      S_COUNT: if (w_byte) begin
        w_remain_n = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        w_state_n  = S_DATA;
      end
      S_DATA: if (w_byte) begin
        w_wr_en_n   = 1'b1;
        w_wr_addr_n = r_ptr;
        w_wr_data_n = rx_data;
        w_ptr_n     = (r_ptr == FB_BYTES - 14'd1) ? 14'd0 : r_ptr + 14'd1;
        w_remain_n  = r_remain - 9'd1;
        if (r_remain == 9'd1) w_state_n = S_IDLE;
      end
      S_FILL_VAL: if (w_byte) begin
        w_fill_val_n = rx_data;
        w_fill_cnt_n = 14'd0;
        w_busy_n     = 1'b1;
        w_state_n    = S_FILLING;
      end
      // busy stays high through the edge that issues the last fill write
      S_FILLING: begin
        w_busy_n     = 1'b1;
        w_wr_en_n    = 1'b1;
        w_wr_addr_n  = r_fill_cnt;
        w_wr_data_n  = r_fill_val;
        w_fill_cnt_n = r_fill_cnt + 14'd1;
        if (r_fill_cnt == FB_BYTES - 14'd1) w_state_n = S_IDLE;
      end
`ifdef PIXEL_WRITE_EN
      S_PX_XHI: if (w_byte) begin
        w_px_x_n  = {rx_data[0], r_px_x[7:0]};
        w_state_n = S_PX_XLO;
      end
      S_PX_XLO: if (w_byte) begin
        w_px_x_n  = {r_px_x[8], rx_data};
        w_state_n = S_PX_Y;
      end
      S_PX_Y: if (w_byte) begin
        w_px_y_n  = rx_data;
        w_state_n = S_PX_COL;
      end
      S_PX_COL: if (w_byte) begin
        if (r_px_x < 9'd320 && r_px_y < 8'd240) begin
          w_px_c_n    = rx_data[0];
          w_rd_addr_n = w_px_addr;
          w_busy_n    = 1'b1;
          w_state_n   = S_PX_RD;
        end else begin
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      S_PX_RD: begin
        w_busy_n  = 1'b1;
        w_state_n = S_PX_CAP;
      end
      S_PX_CAP: begin
        w_wr_en_n   = 1'b1;
        w_wr_addr_n = r_rd_addr;
        w_wr_data_n = w_px_byte;
        w_state_n   = S_IDLE;
      end
`endif
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_addr_hi  <= '0;
      r_remain   <= '0;
      r_fill_val <= '0;
      r_fill_cnt <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
`ifdef PIXEL_WRITE_EN
      r_px_x     <= '0;
      r_px_y     <= '0;
      r_px_c     <= 1'b0;
      r_rd_addr  <= '0;
`endif
    end else begin
      r_state    <= w_state_n;
      r_ptr      <= w_ptr_n;
      r_addr_hi  <= w_addr_hi_n;
      r_remain   <= w_remain_n;
      r_fill_val <= w_fill_val_n;
      r_fill_cnt <= w_fill_cnt_n;
      r_wr_en    <= w_wr_en_n;
      r_wr_addr  <= w_wr_addr_n;
      r_wr_data  <= w_wr_data_n;
      r_busy     <= w_busy_n;
      r_err      <= w_err_n;
`ifdef PIXEL_WRITE_EN
      r_px_x     <= w_px_x_n;
      r_px_y     <= w_px_y_n;
      r_px_c     <= w_px_c_n;
      r_rd_addr  <= w_rd_addr_n;
`endif
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = r_busy;
  assign cmd_error = r_err;
`ifdef PIXEL_WRITE_EN
  assign fb_rd_addr = r_rd_addr;
`endif

endmodule

// File: tb/tb_serial_fb_writer.sv
// Scoreboard bench for serial_fb_writer: a command-level model predicts every write and its cycle.
module tb_serial_fb_writer;
  localparam int FB = 9600;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [13:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        cmd_error;
`ifdef PIXEL_WRITE_EN
  logic [13:0] fb_rd_addr;
  logic [7:0]  fb_rd_data;
  logic [7:0]  ram [FB];
`endif

  serial_fb_writer dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .cmd_error(cmd_error)
`ifdef PIXEL_WRITE_EN
    , .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef PIXEL_WRITE_EN
  always @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    fb_rd_data <= ram[fb_rd_addr];
  end
`endif

  typedef struct { logic [13:0] addr; logic [7:0] data; int cyc; } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  pend[$];
  int          m_ptr, m_remain, m_busy_last, last_s;
  logic        m_err;
  logic [7:0]  m_mem [FB];

  function automatic void model_reset();
    m_ptr = 0; m_remain = 0; m_busy_last = -1; m_err = 1'b0;
    pend.delete();
  endfunction

  function automatic void push_exp(int a, logic [7:0] d, int c);
    exp_t e;
    e.addr = 14'(a); e.data = d; e.cyc = c;
    sb.push_back(e);
    m_mem[a] = d;
  endfunction

  // s = edge number at which the DUT samples this byte
  function automatic void model_byte(logic [7:0] b, int s);
    int a;
    if (s <= m_busy_last) begin m_err = 1'b1; return; end
    if (m_remain > 0) begin
      push_exp(m_ptr, b, s);
      m_ptr = (m_ptr + 1) % FB;
      m_remain--;
      return;
    end
    pend.push_back(b);
    case (pend[0])
      8'hA0: if (pend.size() == 3) begin
        a = int'(pend[1][5:0]) * 256 + int'(pend[2]);
        if (a < FB) m_ptr = a; else begin m_ptr = 0; m_err = 1'b1; end
        pend.delete();
      end
      8'hA1: if (pend.size() == 2) begin
        m_remain = (pend[1] == 8'd0) ? 256 : int'(pend[1]);
        pend.delete();
      end
      8'hA2: if (pend.size() == 2) begin
        for (int i = 0; i < FB; i++) push_exp(i, pend[1], s + 1 + i);
        m_busy_last = s + FB + 1;
        pend.delete();
      end
`ifdef PIXEL_WRITE_EN
      8'hA3: if (pend.size() == 5) begin
        int x, y;
        logic [7:0] v;
        x = int'(pend[1][0]) * 256 + int'(pend[2]);
        y = int'(pend[3]);
        if (x < 320 && y < 240) begin
          a = y * 40 + x / 8;
          v = m_mem[a];
          v[x % 8] = pend[4][0];
          push_exp(a, v, s + 2);
          m_busy_last = s + 2;
        end else m_err = 1'b1;
        pend.delete();
      end
`endif
      default: begin m_err = 1'b1; pend.delete(); end
    endcase
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    last_s = cyc + 1;
    model_byte(b, last_s);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    sb.delete();
    model_reset();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20000) begin @(negedge clk); n++; end
    chk("drain_pending", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // monitor: every write the DUT presents must match the next expected one, in the expected cycle
  initial forever begin
    @(negedge clk);
    if (wr_en === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", wr_addr, wr_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data || cyc != e.cyc) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                   wr_addr, wr_data, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] a;
    logic [7:0]  hb;
    int n;
    rx_data = 8'd0; rx_valid = 1'b0; reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", cmd_error, 0);

    // burst at 16
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hA1); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF);
    // wrap from last address
    send_byte(8'hA0); send_byte(8'h25); send_byte(8'h7F);
    send_byte(8'hA1); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22);
    drain();
    chk("err_clean", cmd_error, 0);

    // full fill with a stray byte mid-fill
    send_byte(8'hA2); send_byte(8'hC3);
    chk("busy_fill", busy, 1);
    repeat (500) @(negedge clk);
    send_byte(8'h3C);
    chk("err_midfill", cmd_error, m_err);
    drain();
    chk("busy_after_fill", busy, 0);
    // pointer survives fill: 19 after wrap write 0... pointer is 1
    send_byte(8'hA1); send_byte(8'h01); send_byte(8'h66);
    drain();

    // out-of-range address
    do_reset();
    send_byte(8'hA0); send_byte(8'h25); send_byte(8'h80);
    chk("err_badaddr", cmd_error, m_err);
    send_byte(8'hA1); send_byte(8'h01); send_byte(8'h33);
    drain();

    // unknown opcode
    do_reset();
    chk("err_after_reset", cmd_error, 0);
    send_byte(8'h5A);
    chk("err_opcode", cmd_error, m_err);

    // reset in the middle of a fill
    do_reset();
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hA2); send_byte(8'hE7);
    while (cyc < last_s + 101) @(negedge clk);
    chk("fill_at_100", wr_addr, 100);
    reset_n = 1'b0;
    @(negedge clk);
    chk("rstfill_wr_en", wr_en, 0);
    chk("rstfill_busy", busy, 0);
    sb.delete();
    model_reset();
    reset_n = 1'b1;
    send_byte(8'hA1); send_byte(8'h01); send_byte(8'h7E);
    drain();
    chk("rstfill_err", cmd_error, 0);

`ifdef PIXEL_WRITE_EN
    do_reset();
    send_byte(8'hA0); send_byte(8'h01); send_byte(8'h92);
    send_byte(8'hA1); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hA3); send_byte(8'h00); send_byte(8'h13); send_byte(8'h0A); send_byte(8'h01);
    drain();
    chk("px_err", cmd_error, 0);
    send_byte(8'hA3); send_byte(8'h00); send_byte(8'h05); send_byte(8'hF0); send_byte(8'h01);
    drain();
    chk("px_bad_y", cmd_error, m_err);
`endif

    // randomized bursts, including one 256-byte burst
    do_reset();
    send_byte(8'hA0); send_byte(8'h20); send_byte(8'h00);
    send_byte(8'hA1); send_byte(8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'($urandom));
    drain();
    for (int it = 0; it < 25; it++) begin
      if (it % 7 == 6) a = 14'($urandom_range(9600, 16383));
      else if ($urandom_range(0, 3) == 0) a = 14'($urandom_range(9590, 9599));
      else a = 14'($urandom_range(0, 9599));
      hb = 8'($urandom);
      hb[5:0] = a[13:8];
      send_byte(8'hA0); send_byte(hb); send_byte(a[7:0]);
      n = $urandom_range(1, 6);
      send_byte(8'hA1); send_byte(8'(n));
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send_byte(8'($urandom));
      end
      chk("err_rand", cmd_error, m_err);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
